cache_miss_ctrl: RTL and testbench
==================================

Name: cache_miss_ctrl

Overview:
Controller that sits directly upstream of the 64-entry direct-mapped cache (26-bit tag, 6-bit index, 32-bit data). It takes CPU load/store requests, drives the cache's addr/rden/wren/wrData, and reads its combinational MemHit and q. On a read miss or a store, it runs a handshake with backing memory and refills the cache. Stores are write-through with write-allocate. The block also keeps saturating hit and miss counters for performance measurement.

Parameters:
CNT_W, 16, width of the hit_cnt and miss_cnt performance counters
MEM_TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting a memory transaction

Ports:
clk  in  1  single system clock, rising-edge logic
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  request valid; CPU holds req/we/addr/wdata stable until cpu_done
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  word address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid while cpu_done=1
cpu_done  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle pulse with cpu_done when a memory timeout occurred
c_addr  out  32  to cache addr
c_rden  out  1  to cache rden
c_wren  out  1  to cache wren (the cache samples on negedge clk)
c_wrdata  out  32  to cache wrData
c_hit  in  1  from cache MemHit
c_q  in  32  from cache q
mem_req  out  1  memory request, held high until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_ack  in  1  one-cycle acknowledge from memory; mem_rdata is valid in the same cycle
mem_rdata  in  32  memory read data
hit_cnt  out  CNT_W  saturating count of read hits
miss_cnt  out  CNT_W  saturating count of read misses

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0, counters are 0, and the addr/data/timer registers are cleared. Cache contents are not touched.
- Reset asserted mid-transaction: mem_req drops immediately with no completion pulse. Memory must tolerate the abandoned request.
- c_addr = cpu_addr in IDLE, and the latched address in every other state. c_rden = 1 in IDLE while cpu_req=1 and cpu_we=0, otherwise 0.
- FSM states:
  - IDLE:
    - req, load, c_hit=1: cpu_rdata=c_q and cpu_done=1 in the same cycle (0-cycle hit latency); hit_cnt++; stay in IDLE.
    - req, load, c_hit=0: latch addr; miss_cnt++; go to RD_MEM.
    - req, store: latch addr and wdata; go to WR_MEM.
  - RD_MEM: mem_req=1, mem_we=0, mem_addr=latched addr.
    - mem_ack: latch mem_rdata; go to FILL.
    - timer hits MEM_TIMEOUT: go to ERR.
  - FILL: c_wren=1, c_wrdata=latched data, for exactly one cycle; go to RESP.
  - WR_MEM: mem_req=1, mem_we=1, mem_wdata=latched wdata.
    - mem_ack: go to FILL, with the latched data being the store data. In RESP, cpu_rdata then equals the store data.
    - timeout: go to ERR.
  - RESP: cpu_done=1, cpu_rdata=latched data; go to IDLE.
  - ERR: cpu_done=1, cpu_err=1, cpu_rdata=0, cache not written; go to IDLE.
- Latency: read hit 0 cycles. Read miss = N + 2 cycles after req, where N = cycles until mem_ack (N ≥ 1). Store = N + 2 cycles.
- Timer: 8-bit, cleared on entry to RD_MEM/WR_MEM, increments each waiting cycle. A timeout fires when timer == MEM_TIMEOUT and mem_ack=0. If mem_ack and the timeout boundary occur in the same cycle, the ack wins.
- A new request is accepted only in IDLE. The cycle after cpu_done is IDLE again, so back-to-back requests are allowed.
- A store does not increment either counter. Counters saturate at all-ones and never wrap.
- mem_ack outside RD_MEM/WR_MEM is ignored.

Decomposition:
- Shared package cache_pkg:
  - constants TAG_W=26, IDX_W=6, DATA_W=32
  - the cache entry struct (valid, tag, data)
  - enum ctrl_state_t {IDLE, RD_MEM, WR_MEM, FILL, RESP, ERR}
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instanced twice for hit_cnt and miss_cnt.

Test Plan:
- Cold read 0x0000_0044, mem_ack after 3 cycles with rdata 0xDEAD_BEEF → miss_cnt=1; c_wren pulses once with 0xDEAD_BEEF; cpu_done with cpu_rdata=0xDEAD_BEEF 5 cycles after req. Re-read 0x44 → cpu_done same cycle, rdata 0xDEAD_BEEF, hit_cnt=1.
- Conflict: read 0x0000_0084 (same index 0x04, different tag) after the above → miss, refill, then re-read 0x44 misses again (miss_cnt=3).
- Store 0x0000_0010 ← 0x1234_5678 → mem_we=1, mem_wdata=0x1234_5678, cache filled. Following read 0x10 hits with 0x1234_5678; counters unchanged by the store.
- No mem_ack for MEM_TIMEOUT cycles on a read miss → cpu_done=cpu_err=1, cpu_rdata=0, c_wren never asserted, next read of the same address still misses.
- Assert rst during RD_MEM → mem_req=0 in the same cycle, state IDLE, counters 0, no cpu_done. A late mem_ack afterwards is ignored.
- Force hit_cnt near all-ones (CNT_W=4 build), issue 20 hits → hit_cnt holds at 15.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped cache and its miss controller.
// The cache is 64 entries, word addressed, split into a 6-bit index and a 26-bit tag.
package cache_pkg;

  localparam int unsigned TAG_W  = 26;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = TAG_W + IDX_W;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cache_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_MEM,
    WR_MEM,
    FILL,
    RESP,
    ERR
  } ctrl_state_t;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:IDX_W];
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_sat_counter.sv
// Saturating up-counter used for cache hit/miss performance statistics.
// It sticks at all-ones rather than wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss controller in front of the direct-mapped cache: serves read hits in zero
// cycles, refills on read misses, and handles write-through/write-allocate stores.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       c_addr,
  output logic              c_rden,
  output logic              c_wren,
  output logic [31:0]       c_wrdata,
  input  logic              c_hit,
  input  logic [31:0]       c_q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

  ctrl_state_t       state;
  ctrl_state_t       next_state;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        timer;
  logic              timed_out;
  logic              hit_inc;
  logic              miss_inc;

  // An ack arriving on the boundary cycle takes priority over the timeout.
  assign timed_out = (timer == TIMEOUT_V) && !mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we)      next_state = WR_MEM;
          else if (!c_hit) next_state = RD_MEM;
        end
      end
      RD_MEM, WR_MEM: begin
        if (mem_ack)        next_state = FILL;
        else if (timed_out) next_state = ERR;
      end
      FILL:    next_state = RESP;
      RESP:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (cpu_req && (cpu_we || !c_hit)) begin
            addr_q <= cpu_addr;
            data_q <= cpu_wdata;
          end
        end
        RD_MEM: begin
          timer <= timer + 1'b1;
          if (mem_ack) data_q <= mem_rdata;
        end
        WR_MEM: timer <= timer + 1'b1;
        default: ;
      endcase
    end
  end

  // Held at zero during reset so an abandoned memory request drops immediately.
  always_comb begin
    cpu_rdata = '0;
    cpu_done  = 1'b0;
    cpu_err   = 1'b0;
    c_addr    = '0;
    c_rden    = 1'b0;
    c_wren    = 1'b0;
    c_wrdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    if (!rst) begin
      c_addr = addr_q;
      case (state)
        IDLE: begin
          c_addr = cpu_addr;
          c_rden = cpu_req && !cpu_we;
          if (cpu_req && !cpu_we) begin
            if (c_hit) begin
              cpu_done  = 1'b1;
              cpu_rdata = c_q;
              hit_inc   = 1'b1;
            end else begin
              miss_inc  = 1'b1;
            end
          end
        end
        RD_MEM: begin
          mem_req  = 1'b1;
          mem_addr = addr_q;
        end
        WR_MEM: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = data_q;
        end
        FILL: begin
          c_wren   = 1'b1;
          c_wrdata = data_q;
        end
        RESP: begin
          cpu_done  = 1'b1;
          cpu_rdata = data_q;
        end
        ERR: begin
          cpu_done = 1'b1;
          cpu_err  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl with a behavioural 64-entry cache model;
// built with 4-bit counters so saturation is reachable.
module tb_cache_miss_ctrl;
  import cache_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic              cpu_done, cpu_err;
  logic [31:0]       c_addr, c_wrdata, c_q;
  logic              c_rden, c_wren, c_hit;
  logic              mem_req, mem_we, mem_ack;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  int tests = 0;
  int fails = 0;
  int wren_cnt = 0;

  cache_entry_t cache_mem [64];

  always #5 clk = ~clk;

  cache_miss_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .c_addr(c_addr), .c_rden(c_rden), .c_wren(c_wren), .c_wrdata(c_wrdata),
    .c_hit(c_hit), .c_q(c_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Cache model: combinational lookup, write on falling edge.
  always_comb begin
    c_hit = cache_mem[idx_of(c_addr)].valid && (cache_mem[idx_of(c_addr)].tag == tag_of(c_addr));
    c_q   = cache_mem[idx_of(c_addr)].data;
  end

  always @(negedge clk) begin
    if (c_wren) begin
      cache_mem[idx_of(c_addr)] = '{valid: 1'b1, tag: tag_of(c_addr), data: c_wrdata};
      wren_cnt = wren_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #3;
  endtask

  // Runs one miss or store; ends in the completion cycle (RESP or ERR).
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int unsigned n, input logic give_ack, input logic [31:0] rdata);
    logic [31:0] exp;
    int w0;
    w0 = wren_cnt;
    exp = we ? wdata : rdata;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    chk("idle_rden", 32'(c_rden), 32'(!we));
    chk("idle_no_done", 32'(cpu_done), 32'd0);
    for (int unsigned i = 1; i <= n; i++) begin
      cyc;
      if (give_ack && i == n) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      #1;
      if (i == n) begin
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_addr", mem_addr, addr);
        if (we) chk("mem_wdata", mem_wdata, wdata);
        chk("wait_no_done", 32'(cpu_done), 32'd0);
      end
    end
    cyc;
    mem_ack = 1'b0;
    #1;
    if (give_ack) begin
      chk("fill_wren", 32'(c_wren), 32'd1);
      chk("fill_wrdata", c_wrdata, exp);
      chk("fill_no_done", 32'(cpu_done), 32'd0);
      cyc;
      #1;
    end
    chk("done", 32'(cpu_done), 32'd1);
    chk("err", 32'(cpu_err), 32'(!give_ack));
    chk("rdata", cpu_rdata, give_ack ? exp : 32'd0);
    chk("wren_pulses", 32'(wren_cnt - w0), give_ack ? 32'd1 : 32'd0);
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    #1;
    chk("hit_done", 32'(cpu_done), 32'd1);
    chk("hit_rdata", cpu_rdata, exp);
    chk("hit_err", 32'(cpu_err), 32'd0);
  endtask

  initial begin
    int w_before;
    for (int i = 0; i < 64; i++) cache_mem[i] = '0;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wren", 32'(c_wren), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    rst = 1'b0;

    // Cold read miss, N=3, then a zero-latency re-read hit.
    cyc;
    txn(1'b0, 32'h44, 32'h0, 3, 1'b1, 32'hDEAD_BEEF);
    chk("miss_cnt_1", 32'(miss_cnt), 32'd1);
    cyc;
    do_hit(32'h44, 32'hDEAD_BEEF);
    cyc;
    cpu_req = 1'b0;
    #1;
    chk("hit_cnt_1", 32'(hit_cnt), 32'd1);

    // Conflict on index 4: 0x84 evicts 0x44, which then misses again.
    cyc;
    txn(1'b0, 32'h84, 32'h0, 2, 1'b1, 32'hCAFE_0084);
    cyc;
    txn(1'b0, 32'h44, 32'h0, 1, 1'b1, 32'hDEAD_BEEF);
    chk("miss_cnt_3", 32'(miss_cnt), 32'd3);

    // Store with write-allocate; following read hits, counters unchanged by store.
    cyc;
    txn(1'b1, 32'h10, 32'h1234_5678, 2, 1'b1, 32'hFFFF_FFFF);
    chk("store_no_cnt", 32'(miss_cnt), 32'd3);
    cyc;
    do_hit(32'h10, 32'h1234_5678);
    cyc;
    cpu_req = 1'b0;
    #1;
    chk("hit_cnt_2", 32'(hit_cnt), 32'd2);
    chk("miss_cnt_still_3", 32'(miss_cnt), 32'd3);

    // Timeout on a read miss, then the same address misses again with ack on the boundary.
    cyc;
    txn(1'b0, 32'h200, 32'h0, 256, 1'b0, 32'h0);
    chk("miss_cnt_4", 32'(miss_cnt), 32'd4);
    cyc;
    txn(1'b0, 32'h200, 32'h0, 256, 1'b1, 32'hA5A5_0200);
    chk("miss_cnt_5", 32'(miss_cnt), 32'd5);
    cyc;
    cpu_req = 1'b0;

    // Reset in the middle of RD_MEM; a late ack must be ignored.
    cyc;
    w_before = wren_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    cyc;
    cyc;
    #1;
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_done", 32'(cpu_done), 32'd0);
    chk("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
    cyc;
    rst = 1'b0; cpu_req = 1'b0;
    cyc;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    chk("late_ack_done", 32'(cpu_done), 32'd0);
    cyc;
    mem_ack = 1'b0;
    #1;
    chk("late_ack_wren", 32'(c_wren), 32'd0);
    chk("late_ack_done2", 32'(cpu_done), 32'd0);
    cyc;
    #1;
    chk("late_ack_no_fill", 32'(wren_cnt - w_before), 32'd0);

    // Hit counter saturation: 20+ consecutive hits on 0x10 with a 4-bit counter.
    cyc;
    do_hit(32'h10, 32'h1234_5678);
    for (int i = 0; i < 14; i++) cyc;
    #1;
    chk("hit_cnt_14", 32'(hit_cnt), 32'd14);
    for (int i = 0; i < 6; i++) cyc;
    #1;
    chk("hit_cnt_sat", 32'(hit_cnt), 32'd15);
    chk("sat_still_done", 32'(cpu_done), 32'd1);
    cyc;
    cpu_req = 1'b0;
    #1;
    chk("hit_cnt_hold", 32'(hit_cnt), 32'd15);
    chk("miss_cnt_zero", 32'(miss_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
